// File: rtl/eth_udp_rx_if.sv
// eth_udp_rx_if: payload write side of the UDP receiver.
// master: wrdata_fifo/wren_fifo out, afull_flag in.
interface eth_udp_rx_if;
  logic [7:0] wrdata_fifo;
  logic       wren_fifo;
  logic       afull_flag;

  modport master (
    output wrdata_fifo,
    output wren_fifo,
    input  afull_flag
  );

  modport slave (
    input  wrdata_fifo,
    input  wren_fifo,
    output afull_flag
  );
endinterface

// File: rtl/eth_udp_rx.sv
// eth_udp_rx: GMII UDP receiver, filters MAC/IP/port, streams payload.
// E_RXC/rst_n/E_RXD/E_RXDV in; fifo (master) out; rx_done + status out.
module eth_udp_rx #(
  parameter logic [47:0] LOCAL_MAC  = 48'h000c2961b41b,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A80002,
  parameter logic [15:0] LOCAL_PORT = 16'd8080,
  parameter logic [15:0] MAX_DATA   = 16'd1472
) (
  input  logic        E_RXC,
  input  logic        rst_n,
  input  logic [7:0]  E_RXD,
  input  logic        E_RXDV,
  eth_udp_rx_if.master fifo,
  output logic        rx_done,
  output logic        rx_crc_ok,
  output logic        rx_drop,
  output logic [15:0] rx_len,
  output logic [15:0] src_port
);

  typedef enum logic [3:0] {
    R_IDLE,
    R_PREAMBLE,
    R_ENET_HEAD,
    R_IP_HEAD,
    R_UDP_HEAD,
    R_UDP_DATA,
    R_PAD,
    R_DROP,
    R_END
  } state_t;

  // MSB-first CRC32, data bits taken LSB first (Ethernet bit order).
  function automatic logic [31:0] crc32_d8(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = {r[30:0], 1'b0} ^
          ((r[31] ^ d[i]) ? 32'h04C11DB7 : 32'h0);
    end
    return r;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  state_t      state;
  logic [7:0]  rxd1;
  logic        rxdv1;
  logic [3:0][7:0] dl;
  logic [3:0]  dl_mark;
  logic [31:0] crc;
  logic [47:0] hdr;
  logic [15:0] cnt;
  logic [15:0] wr_cnt;
  logic [15:0] udp_len;
  logic [15:0] sport_r;
  logic        ok;
  logic        drop_f;

  logic        fall;
  logic        mark_in;
  logic        sfd;
  logic        fcs_ok;
  logic [15:0] last16;
  logic [31:0] last32;
  logic [47:0] last48;

  assign last16 = {hdr[7:0], rxd1};
  assign last32 = {hdr[23:0], rxd1};
  assign last48 = {hdr[39:0], rxd1};

  // Frame end seen at stage 1 while a frame is in progress.
  assign fall = !rxdv1 && state != R_IDLE && state != R_END;

  // Bytes after the SFD are tagged so the CRC picks them up
  // when they leave the delay line.
  assign mark_in = rxdv1 && state != R_IDLE &&
                   state != R_PREAMBLE && state != R_END;

  assign sfd = state == R_PREAMBLE && rxdv1 && rxd1 == 8'hD5;

  // The delay line holds the FCS, oldest byte in dl[3].
  assign fcs_ok = dl[3] == ~rev8(crc[31:24]) &&
                  dl[2] == ~rev8(crc[23:16]) &&
                  dl[1] == ~rev8(crc[15:8])  &&
                  dl[0] == ~rev8(crc[7:0]);

  always_ff @(posedge E_RXC or negedge rst_n) begin
    if (!rst_n) begin
      rxd1    <= 8'h0;
      rxdv1   <= 1'b0;
      dl      <= '0;
      dl_mark <= '0;
      crc     <= 32'hffffffff;
    end else begin
      rxd1    <= E_RXD;
      rxdv1   <= E_RXDV;
      dl      <= {dl[2:0], rxd1};
      dl_mark <= {dl_mark[2:0], mark_in};
      if (sfd)
        crc <= 32'hffffffff;
      else if (dl_mark[3])
        crc <= crc32_d8(crc, dl[3]);
    end
  end

  always_ff @(posedge E_RXC or negedge rst_n) begin
    if (!rst_n) begin
      state            <= R_IDLE;
      hdr              <= '0;
      cnt              <= '0;
      wr_cnt           <= '0;
      udp_len          <= '0;
      sport_r          <= '0;
      ok               <= 1'b0;
      drop_f           <= 1'b0;
      fifo.wrdata_fifo <= 8'h0;
      fifo.wren_fifo   <= 1'b0;
      rx_done          <= 1'b0;
      rx_crc_ok        <= 1'b0;
      rx_drop          <= 1'b0;
      rx_len           <= '0;
      src_port         <= '0;
    end else begin
      fifo.wren_fifo <= 1'b0;
      rx_done        <= 1'b0;
      hdr            <= {hdr[39:0], rxd1};
      if (fall) begin
        // Only a frame that reached the padding/FCS is complete.
        state     <= R_END;
        rx_done   <= 1'b1;
        rx_crc_ok <= state == R_PAD && fcs_ok;
        rx_drop   <= drop_f || state != R_PAD;
        rx_len    <= wr_cnt;
        src_port  <= sport_r;
      end else begin
        unique case (state)
          R_IDLE: begin
            if (rxdv1 && rxd1 == 8'h55) begin
              state   <= R_PREAMBLE;
              cnt     <= 16'd1;
              wr_cnt  <= '0;
              udp_len <= '0;
              sport_r <= '0;
              ok      <= 1'b1;
              drop_f  <= 1'b0;
            end
          end
          R_PREAMBLE: begin
            if (rxd1 == 8'h55 && cnt != 16'd7) begin
              cnt <= cnt + 16'd1;
            end else if (rxd1 == 8'hD5) begin
              state <= R_ENET_HEAD;
              cnt   <= '0;
            end else begin
              state  <= R_DROP;
              drop_f <= 1'b1;
            end
          end
          R_ENET_HEAD: begin
            cnt <= cnt + 16'd1;
            if (cnt == 16'd5 && last48 != LOCAL_MAC &&
                last48 != 48'hffffffffffff)
              ok <= 1'b0;
            if (cnt == 16'd13) begin
              cnt <= '0;
              if (ok && last16 == 16'h0800) begin
                state <= R_IP_HEAD;
              end else begin
                state  <= R_DROP;
                drop_f <= 1'b1;
              end
            end
          end
          R_IP_HEAD: begin
            cnt <= cnt + 16'd1;
            if (cnt == 16'd0 && rxd1 != 8'h45) ok <= 1'b0;
            if (cnt == 16'd9 && rxd1 != 8'h11) ok <= 1'b0;
            if (cnt == 16'd19) begin
              cnt <= '0;
              if (ok && last32 == LOCAL_IP) begin
                state <= R_UDP_HEAD;
              end else begin
                state  <= R_DROP;
                drop_f <= 1'b1;
              end
            end
          end
          R_UDP_HEAD: begin
            cnt <= cnt + 16'd1;
            if (cnt == 16'd1) sport_r <= last16;
            if (cnt == 16'd3 && last16 != LOCAL_PORT) ok <= 1'b0;
            if (cnt == 16'd5) begin
              udp_len <= last16;
              if (last16 < 16'd8) ok <= 1'b0;
            end
            if (cnt == 16'd7) begin
              cnt <= '0;
              // afull here means no payload write ever starts.
              if (!ok || fifo.afull_flag) begin
                state  <= R_DROP;
                drop_f <= 1'b1;
              end else if (udp_len == 16'd8) begin
                state <= R_PAD;
              end else begin
                state <= R_UDP_DATA;
              end
            end
          end
          R_UDP_DATA: begin
            cnt <= cnt + 16'd1;
            if (cnt < MAX_DATA) begin
              fifo.wren_fifo   <= 1'b1;
              fifo.wrdata_fifo <= rxd1;
              wr_cnt           <= wr_cnt + 16'd1;
            end else begin
              drop_f <= 1'b1;
            end
            if (cnt == udp_len - 16'd9) state <= R_PAD;
          end
          R_PAD, R_DROP: begin
            state <= state;
          end
          R_END: begin
            state <= R_IDLE;
          end
          default: begin
            state <= R_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_udp_rx.sv
// tb_eth_udp_rx: directed frames into eth_udp_rx.
// Checks payload writes and per-frame status.
module tb_eth_udp_rx;

  localparam logic [47:0] MAC = 48'h000c2961b41b;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rxd = 8'h0;
  logic        rxdv = 1'b0;
  logic        rx_done;
  logic        rx_crc_ok;
  logic        rx_drop;
  logic [15:0] rx_len;
  logic [15:0] src_port;

  eth_udp_rx_if fifo ();

  eth_udp_rx dut (
    .E_RXC(clk),
    .rst_n(rst_n),
    .E_RXD(rxd),
    .E_RXDV(rxdv),
    .fifo(fifo),
    .rx_done(rx_done),
    .rx_crc_ok(rx_crc_ok),
    .rx_drop(rx_drop),
    .rx_len(rx_len),
    .src_port(src_port)
  );

  always #4 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]  frm[$];
  logic [7:0]  wq[$];
  int          done_cnt = 0;
  logic        d_crc = 1'b0;
  logic        d_drop = 1'b0;
  logic [15:0] d_len = '0;
  logic [15:0] d_port = '0;

  always @(negedge clk) begin
    if (fifo.wren_fifo) wq.push_back(fifo.wrdata_fifo);
    if (rx_done) begin
      done_cnt = done_cnt + 1;
      d_crc    = rx_crc_ok;
      d_drop   = rx_drop;
      d_len    = rx_len;
      d_port   = src_port;
    end
  end

  // Builds a frame: preamble, headers, payload 0,1,2.., pad, FCS.
  task automatic build(
    input logic [47:0] dmac,
    input logic [15:0] dport,
    input int plen
  );
    logic [15:0] ipl;
    logic [15:0] ul;
    logic [31:0] c;
    logic [47:0] smac;
    logic [7:0]  iph[20];
    ipl  = 16'(28 + plen);
    ul   = 16'(8 + plen);
    smac = 48'h000a3501fec0;
    iph  = '{8'h45, 8'h00, ipl[15:8], ipl[7:0], 8'h00, 8'h00,
             8'h40, 8'h00, 8'h80, 8'h11, 8'h00, 8'h00,
             8'hc0, 8'ha8, 8'h00, 8'h03,
             8'hc0, 8'ha8, 8'h00, 8'h02};
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hd5);
    for (int i = 5; i >= 0; i--) frm.push_back(dmac[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) frm.push_back(smac[i*8 +: 8]);
    frm.push_back(8'h08);
    frm.push_back(8'h00);
    for (int i = 0; i < 20; i++) frm.push_back(iph[i]);
    frm.push_back(8'h1f);
    frm.push_back(8'h90);
    frm.push_back(dport[15:8]);
    frm.push_back(dport[7:0]);
    frm.push_back(ul[15:8]);
    frm.push_back(ul[7:0]);
    frm.push_back(8'h00);
    frm.push_back(8'h00);
    for (int i = 0; i < plen; i++) frm.push_back(8'(i));
    while (frm.size() < 68) frm.push_back(8'h00);
    // Reflected Ethernet CRC over MAC header onward.
    c = 32'hffffffff;
    for (int i = 8; i < frm.size(); i++) begin
      c = c ^ {24'h0, frm[i]};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
  endtask

  // Sends frm (or its first cut bytes), then a 12-cycle gap.
  task automatic send(input int cut);
    int n;
    n = (cut < 0) ? frm.size() : cut;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rxd  = frm[i];
      rxdv = 1'b1;
    end
    @(negedge clk);
    rxd  = 8'h0;
    rxdv = 1'b0;
    repeat (12) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({fifo.wren_fifo, rx_done, rx_crc_ok, rx_drop} !== 4'b0) begin
      $display("FAIL reset_flags: got %b exp 0000",
        {fifo.wren_fifo, rx_done, rx_crc_ok, rx_drop});
      errors++;
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (rx_len !== 16'd0 || src_port !== 16'd0) begin
      $display("FAIL reset_len_port: got %0d/%0d exp 0/0",
        rx_len, src_port);
      errors++;
    end
    checks++;
    if (fifo.wrdata_fifo !== 8'h0 || rx_done !== 1'b0) begin
      $display("FAIL reset_data: got %h/%b exp 00/0",
        fifo.wrdata_fifo, rx_done);
      errors++;
    end
  endtask

  task automatic test_good;
    int d0;
    build(MAC, 16'd8080, 21);
    wq.delete();
    d0 = done_cnt;
    send(-1);
    checks++;
    if (wq.size() !== 21) begin
      $display("FAIL good_nwr: got %0d exp 21", wq.size());
      errors++;
    end
    for (int i = 0; i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== 8'(i)) begin
        $display("FAIL good_byte%0d: got %h exp %h", i, wq[i], 8'(i));
        errors++;
      end
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      $display("FAIL good_done: got %0d exp 1", done_cnt - d0);
      errors++;
    end
    checks++;
    if ({d_crc, d_drop} !== 2'b10) begin
      $display("FAIL good_flags: got %b exp 10", {d_crc, d_drop});
      errors++;
    end
    checks++;
    if (d_len !== 16'd21 || d_port !== 16'd8080) begin
      $display("FAIL good_len_port: got %0d/%0d exp 21/8080",
        d_len, d_port);
      errors++;
    end
  endtask

  task automatic test_bad_fcs;
    int d0;
    build(MAC, 16'd8080, 21);
    frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
    wq.delete();
    d0 = done_cnt;
    send(-1);
    checks++;
    if (wq.size() !== 21 || wq[20] !== 8'h14) begin
      $display("FAIL badfcs_wr: got %0d writes exp 21", wq.size());
      errors++;
    end
    checks++;
    if (done_cnt - d0 !== 1 || {d_crc, d_drop} !== 2'b00) begin
      $display("FAIL badfcs_flags: got done %0d crc/drop %b exp 1 00",
        done_cnt - d0, {d_crc, d_drop});
      errors++;
    end
  endtask

  task automatic test_filter;
    int d0;
    build(48'h001122334455, 16'd8080, 21);
    wq.delete();
    d0 = done_cnt;
    send(-1);
    checks++;
    if (wq.size() !== 0) begin
      $display("FAIL mac_nwr: got %0d exp 0", wq.size());
      errors++;
    end
    checks++;
    if (done_cnt - d0 !== 1 || d_drop !== 1'b1 || d_len !== 16'd0) begin
      $display("FAIL mac_status: got done %0d drop %b len %0d exp 1 1 0",
        done_cnt - d0, d_drop, d_len);
      errors++;
    end
    build(MAC, 16'd8081, 4);
    wq.delete();
    send(-1);
    checks++;
    if (wq.size() !== 0 || d_drop !== 1'b1) begin
      $display("FAIL port_drop: got %0d writes drop %b exp 0 1",
        wq.size(), d_drop);
      errors++;
    end
    build(48'hffffffffffff, 16'd8080, 3);
    wq.delete();
    send(-1);
    checks++;
    if (wq.size() !== 3 || {d_crc, d_drop} !== 2'b10) begin
      $display("FAIL bcast: got %0d writes crc/drop %b exp 3 10",
        wq.size(), {d_crc, d_drop});
      errors++;
    end
  endtask

  task automatic test_small;
    build(MAC, 16'd8080, 1);
    wq.delete();
    send(-1);
    checks++;
    if (wq.size() !== 1 || wq[0] !== 8'h00) begin
      $display("FAIL pad_wr: got %0d writes exp 1 of 00", wq.size());
      errors++;
    end
    checks++;
    if (d_len !== 16'd1 || {d_crc, d_drop} !== 2'b10) begin
      $display("FAIL pad_status: got len %0d crc/drop %b exp 1 10",
        d_len, {d_crc, d_drop});
      errors++;
    end
    build(MAC, 16'd8080, 0);
    wq.delete();
    send(-1);
    checks++;
    if (wq.size() !== 0 || d_len !== 16'd0 ||
        {d_crc, d_drop} !== 2'b10) begin
      $display("FAIL zero_len: got %0d writes len %0d crc/drop %b exp 0 0 10",
        wq.size(), d_len, {d_crc, d_drop});
      errors++;
    end
  endtask

  task automatic test_afull;
    fifo.afull_flag = 1'b1;
    build(MAC, 16'd8080, 21);
    wq.delete();
    send(-1);
    fifo.afull_flag = 1'b0;
    checks++;
    if (wq.size() !== 0 || d_drop !== 1'b1) begin
      $display("FAIL afull_drop: got %0d writes drop %b exp 0 1",
        wq.size(), d_drop);
      errors++;
    end
    wq.delete();
    send(-1);
    checks++;
    if (wq.size() !== 21 || {d_crc, d_drop} !== 2'b10 ||
        d_len !== 16'd21) begin
      $display("FAIL afull_next: got %0d writes crc/drop %b exp 21 10",
        wq.size(), {d_crc, d_drop});
      errors++;
    end
  endtask

  task automatic test_truncate;
    build(MAC, 16'd8080, 1472);
    wq.delete();
    send(-1);
    checks++;
    if (wq.size() !== 1472 || d_len !== 16'd1472 ||
        {d_crc, d_drop} !== 2'b10) begin
      $display("FAIL max_exact: got %0d writes len %0d crc/drop %b exp 1472 1472 10",
        wq.size(), d_len, {d_crc, d_drop});
      errors++;
    end
    build(MAC, 16'd8080, 1473);
    wq.delete();
    send(-1);
    checks++;
    if (wq.size() !== 1472 || d_len !== 16'd1472 ||
        {d_crc, d_drop} !== 2'b11) begin
      $display("FAIL trunc: got %0d writes len %0d crc/drop %b exp 1472 1472 11",
        wq.size(), d_len, {d_crc, d_drop});
      errors++;
    end
    checks++;
    if (wq.size() == 1472 && wq[1471] !== 8'hbf) begin
      $display("FAIL trunc_last: got %h exp bf", wq[1471]);
      errors++;
    end
  endtask

  task automatic test_runt_reset;
    int d0;
    build(MAC, 16'd8080, 21);
    wq.delete();
    d0 = done_cnt;
    send(32);
    checks++;
    if (done_cnt - d0 !== 1 || {d_crc, d_drop} !== 2'b01 ||
        wq.size() !== 0) begin
      $display("FAIL runt: got done %0d crc/drop %b writes %0d exp 1 01 0",
        done_cnt - d0, {d_crc, d_drop}, wq.size());
      errors++;
    end
    d0 = done_cnt;
    for (int i = 0; i < 55; i++) begin
      @(negedge clk);
      rxd  = frm[i];
      rxdv = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    rxdv  = 1'b0;
    rxd   = 8'h0;
    #1;
    checks++;
    if ({fifo.wren_fifo, rx_done, rx_crc_ok, rx_drop} !== 4'b0 ||
        rx_len !== 16'd0 || src_port !== 16'd0) begin
      $display("FAIL midreset_out: got flags %b len %0d port %0d exp 0",
        {fifo.wren_fifo, rx_done, rx_crc_ok, rx_drop}, rx_len, src_port);
      errors++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    checks++;
    if (done_cnt !== d0) begin
      $display("FAIL midreset_done: got %0d exp 0", done_cnt - d0);
      errors++;
    end
    wq.delete();
    d0 = done_cnt;
    send(-1);
    checks++;
    if (done_cnt - d0 !== 1 || wq.size() !== 21 ||
        {d_crc, d_drop} !== 2'b10 || d_port !== 16'd8080) begin
      $display("FAIL after_reset: got done %0d writes %0d crc/drop %b exp 1 21 10",
        done_cnt - d0, wq.size(), {d_crc, d_drop});
      errors++;
    end
  endtask

  initial begin
    fifo.afull_flag = 1'b0;
    test_reset();
    test_good();
    test_bad_fcs();
    test_filter();
    test_small();
    test_afull();
    test_truncate();
    test_runt_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
